// File: rtl/ldpc_decode_sched.sv
// Frame sequencer for a stochastic LDPC decoder: clear, wait, warm-up, decode, latch, finish.
// Outputs decode from the state register, so nothing follows an input in the same cycle.
// No data backpressure; CH_RDY stalls the frame and ABORT returns to IDLE on the next edge.
module ldpc_decode_sched #(
   parameter int INIT_LEN  = 2,
   parameter int WARMUP    = 64,
   parameter int MAX_CYC   = 1024,
   parameter int PASS_HOLD = 16,
   parameter int CYCW      = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            ch_rdy,
   input  logic            synd_ok,
   output logic            dec_init,
   output logic            node_en,
   output logic            cnt_en,
   output logic            hd_latch,
   output logic            busy,
   output logic            done,
   output logic            converged,
   output logic [CYCW-1:0] cyc_count
);

   // One phase counter serves both CLEAR and WARMUP, so size it for the longer one.
   localparam int PHMAX = (WARMUP > INIT_LEN) ? WARMUP : INIT_LEN;
   localparam int PHW   = $clog2(PHMAX + 1);
   localparam int PSW   = $clog2(PASS_HOLD + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_WAIT_CH, S_WARMUP, S_DECODE, S_LATCH, S_FIN
   } state_t;

   state_t          state, state_nxt;
   logic [PHW-1:0]  ph_cnt;
   logic [PSW-1:0]  pass_cnt;
   logic [PSW-1:0]  pass_nxt;
   logic [CYCW-1:0] cyc_nxt;
   logic            pass_hit, cyc_hit, init_last, warm_last, aborting;

   // Pass counter saturates at PASS_HOLD; any failing syndrome restarts the run.
   assign pass_nxt  = synd_ok ? ((pass_cnt == PSW'(PASS_HOLD)) ? pass_cnt : pass_cnt + 1'b1) : '0;
   assign pass_hit  = (pass_nxt == PSW'(PASS_HOLD));
   assign cyc_nxt   = cyc_count + 1'b1;
   assign cyc_hit   = (cyc_nxt == CYCW'(MAX_CYC));
   assign init_last = (ph_cnt == PHW'(INIT_LEN - 1));
   assign warm_last = (ph_cnt == PHW'(WARMUP - 1));
   assign aborting  = abort && (state != S_IDLE);

   // State register; reset drops every decoded output immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and Moore output decode; ABORT outranks every other transition.
   always_comb begin
      state_nxt = state;
      dec_init  = 1'b0;
      node_en   = 1'b0;
      cnt_en    = 1'b0;
      hd_latch  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:    if (start) state_nxt = S_CLEAR;
         S_CLEAR: begin
            dec_init = 1'b1;
            busy     = 1'b1;
            if (init_last) state_nxt = S_WAIT_CH;
         end
         S_WAIT_CH: begin
            busy = 1'b1;
            if (ch_rdy) state_nxt = S_WARMUP;
         end
         S_WARMUP: begin
            node_en = 1'b1;
            busy    = 1'b1;
            if (warm_last) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            node_en = 1'b1;
            cnt_en  = 1'b1;
            busy    = 1'b1;
            if (pass_hit || cyc_hit) state_nxt = S_LATCH;
         end
         S_LATCH: begin
            hd_latch  = 1'b1;
            busy      = 1'b1;
            state_nxt = S_FIN;
         end
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
      if (aborting) state_nxt = S_IDLE;
   end

   // Phase, pass and cycle counters plus the convergence flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt    <= '0;
         pass_cnt  <= '0;
         cyc_count <= '0;
         converged <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ph_cnt    <= '0;
                  pass_cnt  <= '0;
                  cyc_count <= '0;
                  converged <= 1'b0;
               end
            end
            S_CLEAR:  ph_cnt <= init_last ? '0 : ph_cnt + 1'b1;
            S_WARMUP: ph_cnt <= warm_last ? '0 : ph_cnt + 1'b1;
            S_DECODE: begin
               // The aborted cycle still counts as a decode cycle used.
               cyc_count <= cyc_nxt;
               pass_cnt  <= pass_nxt;
               if (pass_hit) converged <= 1'b1;
            end
            default: ;
         endcase
         if (aborting) begin
            ph_cnt    <= '0;
            pass_cnt  <= '0;
            converged <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ldpc_decode_sched.sv
module tb_ldpc_decode_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, ch_rdy = 1'b0, synd_ok = 1'b0;

   logic dec_init_a, node_en_a, cnt_en_a, hd_latch_a, busy_a, done_a, converged_a;
   logic dec_init_b, node_en_b, cnt_en_b, hd_latch_b, busy_b, done_b, converged_b;
   logic dec_init_c, node_en_c, cnt_en_c, hd_latch_c, busy_c, done_c, converged_c;
   logic [15:0] cyc_count_a, cyc_count_b, cyc_count_c;

   typedef struct packed { logic conv; logic [15:0] cyc; } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ldpc_decode_sched dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_rdy(ch_rdy), .synd_ok(synd_ok),
      .dec_init(dec_init_a), .node_en(node_en_a), .cnt_en(cnt_en_a), .hd_latch(hd_latch_a),
      .busy(busy_a), .done(done_a), .converged(converged_a), .cyc_count(cyc_count_a));

   ldpc_decode_sched #(.MAX_CYC(40)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_rdy(ch_rdy), .synd_ok(synd_ok),
      .dec_init(dec_init_b), .node_en(node_en_b), .cnt_en(cnt_en_b), .hd_latch(hd_latch_b),
      .busy(busy_b), .done(done_b), .converged(converged_b), .cyc_count(cyc_count_b));

   ldpc_decode_sched #(.MAX_CYC(20), .PASS_HOLD(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_rdy(ch_rdy), .synd_ok(synd_ok),
      .dec_init(dec_init_c), .node_en(node_en_c), .cnt_en(cnt_en_c), .hd_latch(hd_latch_c),
      .busy(busy_c), .done(done_c), .converged(converged_c), .cyc_count(cyc_count_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0; abort = 1'b0; ch_rdy = 1'b0; synd_ok = 1'b0;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      int bad = 0;
      rst_n = 1'b0;
      step();
      n_cmp++;
      if ({dec_init_a, node_en_a, cnt_en_a, hd_latch_a, busy_a, done_a, converged_a, cyc_count_a} !== 23'd0) begin
         n_err++;
         $display("FAIL reset_in: outputs=%h want 0",
                  {dec_init_a, node_en_a, cnt_en_a, hd_latch_a, busy_a, done_a, converged_a, cyc_count_a});
      end
      rst_n = 1'b1;
      for (int t = 0; t < 100; t++) begin
         step();
         if ({dec_init_a, node_en_a, cnt_en_a, hd_latch_a, busy_a, done_a, converged_a, cyc_count_a} !== 23'd0)
            bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL reset_idle: %0d nonzero cycles, want 0", bad);
      end
   endtask

   task automatic test_converge();
      int n_init = 0, n_warm = 0, n_dec = 0, n_hl = 0, n_done = 0;
      int first_dec = -1, hl_t = -1, done_t = -1;
      bit fin = 0;
      exp_t e;
      do_reset();
      ch_rdy = 1'b1; synd_ok = 1'b1;
      sb.push_back(exp_t'({1'b1, 16'd16}));
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 300 && !fin; t++) begin
         if (dec_init_a) n_init++;
         if (node_en_a && !cnt_en_a) n_warm++;
         if (cnt_en_a) begin n_dec++; if (first_dec < 0) first_dec = t; end
         if (hd_latch_a) begin n_hl++; hl_t = t; end
         if (done_a) begin
            n_done++; done_t = t;
            n_cmp++;
            if (busy_a !== 1'b0) begin n_err++; $display("FAIL conv_fin_busy: got %b want 0", busy_a); end
            if (sb.size() == 0) begin
               n_err++; $display("FAIL conv_sb: DONE with empty scoreboard");
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (converged_a !== e.conv || cyc_count_a !== e.cyc) begin
                  n_err++;
                  $display("FAIL conv_result: conv=%b cyc=%0d want conv=%b cyc=%0d", converged_a, cyc_count_a, e.conv, e.cyc);
               end
            end
         end
         if (done_t >= 0 && t == done_t + 3) fin = 1;
         step();
      end
      synd_ok = 1'b0;
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL conv_timeout: no DONE within 300 cycles"); sb.delete(); end
      n_cmp++;
      if (n_init !== 2) begin n_err++; $display("FAIL conv_dec_init: %0d cycles want 2", n_init); end
      n_cmp++;
      if (n_warm !== 64) begin n_err++; $display("FAIL conv_warmup: %0d cycles want 64", n_warm); end
      n_cmp++;
      if (n_dec !== 16) begin n_err++; $display("FAIL conv_decode: %0d cycles want 16", n_dec); end
      n_cmp++;
      if (first_dec !== 67) begin n_err++; $display("FAIL conv_latency: first decode at %0d want 67", first_dec); end
      n_cmp++;
      if (n_hl !== 1 || n_done !== 1) begin
         n_err++; $display("FAIL conv_pulses: hd_latch=%0d done=%0d want 1/1", n_hl, n_done);
      end
      n_cmp++;
      if (done_t !== hl_t + 1) begin n_err++; $display("FAIL conv_order: done at %0d want %0d", done_t, hl_t + 1); end
      n_cmp++;
      if (converged_a !== 1'b1 || busy_a !== 1'b0) begin
         n_err++; $display("FAIL conv_hold: converged=%b busy=%b want 1/0", converged_a, busy_a);
      end
   endtask

   task automatic test_budget();
      int k = 0, n_dec = 0, n_hl = 0, n_done = 0;
      bit fin = 0;
      exp_t e;
      do_reset();
      ch_rdy = 1'b1;
      sb.push_back(exp_t'({1'b0, 16'd40}));
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 300 && !fin; t++) begin
         if (cnt_en_b) begin k++; n_dec++; synd_ok = (k % 3) != 0; end
         else synd_ok = 1'b0;
         if (hd_latch_b) n_hl++;
         if (done_b) begin
            n_done++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL budget_sb: DONE with empty scoreboard");
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (converged_b !== e.conv || cyc_count_b !== e.cyc) begin
                  n_err++;
                  $display("FAIL budget_result: conv=%b cyc=%0d want conv=%b cyc=%0d", converged_b, cyc_count_b, e.conv, e.cyc);
               end
            end
         end
         if (n_done > 0 && !busy_b && !done_b) fin = 1;
         step();
      end
      synd_ok = 1'b0;
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL budget_timeout: frame did not finish"); sb.delete(); end
      n_cmp++;
      if (n_dec !== 40) begin n_err++; $display("FAIL budget_decode: %0d cycles want 40", n_dec); end
      n_cmp++;
      if (n_hl !== 1 || n_done !== 1) begin
         n_err++; $display("FAIL budget_pulses: hd_latch=%0d done=%0d want 1/1", n_hl, n_done);
      end
   endtask

   task automatic test_simultaneous();
      int k = 0, n_dec = 0, n_done = 0;
      bit fin = 0;
      exp_t e;
      do_reset();
      ch_rdy = 1'b1;
      sb.push_back(exp_t'({1'b1, 16'd20}));
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 300 && !fin; t++) begin
         if (cnt_en_c) begin k++; n_dec++; synd_ok = (k > 4); end
         else synd_ok = 1'b0;
         if (done_c) begin
            n_done++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL simul_sb: DONE with empty scoreboard");
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (converged_c !== e.conv || cyc_count_c !== e.cyc) begin
                  n_err++;
                  $display("FAIL simul_result: conv=%b cyc=%0d want conv=%b cyc=%0d", converged_c, cyc_count_c, e.conv, e.cyc);
               end
            end
         end
         if (n_done > 0 && !done_c) fin = 1;
         step();
      end
      synd_ok = 1'b0;
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL simul_timeout: frame did not finish"); sb.delete(); end
      n_cmp++;
      if (n_dec !== 20) begin n_err++; $display("FAIL simul_decode: %0d cycles want 20", n_dec); end
   endtask

   task automatic test_stall_abort();
      int stall_bad = 0, k = 0, pulses = 0;
      bit hit = 0;
      exp_t e;
      do_reset();
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      for (int t = 0; t < 50; t++) begin
         if (busy_a !== 1'b1 || node_en_a !== 1'b0 || dec_init_a !== 1'b0) stall_bad++;
         step();
      end
      n_cmp++;
      if (stall_bad !== 0) begin n_err++; $display("FAIL stall: %0d bad cycles want 0", stall_bad); end
      ch_rdy = 1'b1;
      for (int t = 0; t < 200 && !hit; t++) begin
         if (hd_latch_a || done_a) pulses++;
         if (cnt_en_a) begin
            k++;
            if (k == 5) begin
               hit = 1;
               abort = 1'b1;
               sb.push_back(exp_t'({1'b0, 16'd5}));
            end
         end
         step();
      end
      abort = 1'b0;
      n_cmp++;
      if (!hit) begin
         n_err++; $display("FAIL abort_timeout: decode cycle 5 not reached");
      end else begin
         n_cmp++;
         if (busy_a !== 1'b0 || node_en_a !== 1'b0 || cnt_en_a !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: busy=%b node_en=%b cnt_en=%b want 000", busy_a, node_en_a, cnt_en_a);
         end
         e = sb.pop_front();
         n_cmp++;
         if (converged_a !== e.conv || cyc_count_a !== e.cyc) begin
            n_err++;
            $display("FAIL abort_result: conv=%b cyc=%0d want conv=%b cyc=%0d", converged_a, cyc_count_a, e.conv, e.cyc);
         end
      end
      for (int t = 0; t < 10; t++) begin
         if (hd_latch_a || done_a) pulses++;
         step();
      end
      n_cmp++;
      if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses: %0d hd_latch/done cycles want 0", pulses); end
      ch_rdy = 1'b0;
   endtask

   task automatic test_async_reset();
      int k = 0, n_init = 0, first_init = -1;
      do_reset();
      ch_rdy = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 200 && k < 3; t++) begin
         if (cnt_en_a) k++;
         if (k < 3) step();
      end
      n_cmp++;
      if (k !== 3) begin n_err++; $display("FAIL areset_setup: reached %0d decode cycles want 3", k); end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (node_en_a !== 1'b0 || cnt_en_a !== 1'b0 || busy_a !== 1'b0) begin
         n_err++; $display("FAIL areset_drop: node_en=%b cnt_en=%b busy=%b want 000", node_en_a, cnt_en_a, busy_a);
      end
      n_cmp++;
      if (cyc_count_a !== 16'd0 || converged_a !== 1'b0) begin
         n_err++; $display("FAIL areset_regs: cyc=%0d conv=%b want 0/0", cyc_count_a, converged_a);
      end
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1; step(); start = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (dec_init_a) begin n_init++; if (first_init < 0) first_init = t; end
         step();
      end
      n_cmp++;
      if (n_init !== 2 || first_init !== 0) begin
         n_err++; $display("FAIL areset_clear: dec_init %0d cycles from %0d want 2 from 0", n_init, first_init);
      end
      ch_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_converge();
      test_budget();
      test_simultaneous();
      test_stall_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
